// File: rtl/led_command_sequencer_if.sv
// ----------------------------------------------------------------------------
// led_command_sequencer_if
//   Bundle between the processor's memory-mapped LED command registers and the
//   per-LED timing controller.
//
//   Signals
//     led_commands   NUM_LEDS*8  command byte for LED i at [8*i+7:8*i]
//     expired_clear  NUM_LEDS    per-LED level clear of the expiry flag
//     led_pins       NUM_LEDS    registered LED drive
//     led_expired    NUM_LEDS    sticky per-LED timed-on expiry flags
//     tick           1           one-cycle pulse on each prescaler wrap
//
//   Modports
//     master  software / bus side: drives commands and clears
//     slave   the sequencer: drives pins, flags and tick
// ----------------------------------------------------------------------------
interface led_command_sequencer_if #(
    parameter int unsigned NUM_LEDS = 18
);
    logic [NUM_LEDS*8-1:0] led_commands;
    logic [NUM_LEDS-1:0]   expired_clear;
    logic [NUM_LEDS-1:0]   led_pins;
    logic [NUM_LEDS-1:0]   led_expired;
    logic                  tick;

    modport master (
        output led_commands,
        output expired_clear,
        input  led_pins,
        input  led_expired,
        input  tick
    );

    modport slave (
        input  led_commands,
        input  expired_clear,
        output led_pins,
        output led_expired,
        output tick
    );
endinterface

// File: rtl/led_command_sequencer.sv
// ----------------------------------------------------------------------------
// led_command_sequencer
//   Per-LED timing controller for the whack-a-mole board. Each LED has an
//   8-bit command byte: [7:6] mode, [5:0] period p.
//     00 OFF, 01 ON, 10 TIMED (on for p+1 ticks, then off and flag expiry),
//     11 BLINK (toggle every p+1 ticks).
//   A shared prescaler produces a one-cycle tick every TICK_DIV clocks. A byte
//   that differs from the latched copy is a load; loads win over a same-cycle
//   tick for that LED only. led_expired is the sticky "mole timed out" flag.
//
//   Parameters
//     NUM_LEDS  number of LED channels
//     TICK_DIV  clock cycles per tick (>= 1)
//
//   Ports
//     clock  system clock, all state on posedge
//     reset  synchronous, active-high
//     bus    led_command_sequencer_if.slave (commands, clears, pins, flags, tick)
//
//   Build option
//     LED_ACTIVE_LOW_EN  when defined, led_pins is driven inverted (reset value
//                        all-ones, "on" = 0). Everything else is unchanged.
// ----------------------------------------------------------------------------
module led_command_sequencer #(
    parameter int unsigned NUM_LEDS = 18,
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic                   clock,
    input  logic                   reset,
    led_command_sequencer_if.slave bus
);

    localparam int unsigned      PRE_W    = $clog2(TICK_DIV) + 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

`ifdef LED_ACTIVE_LOW_EN
    localparam logic PIN_INV = 1'b1;
`else
    localparam logic PIN_INV = 1'b0;
`endif

    // DONE is internal only: a TIMED channel that has run out holds the pin
    // off until software writes a different byte.
    typedef enum logic [2:0] {
        MODE_OFF,
        MODE_ON,
        MODE_TIMED,
        MODE_BLINK,
        MODE_DONE
    } mode_e;

    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'b00:   return MODE_OFF;
            2'b01:   return MODE_ON;
            2'b10:   return MODE_TIMED;
            default: return MODE_BLINK;
        endcase
    endfunction

    logic [PRE_W-1:0]    pre_cnt;
    logic                tick_q;
    logic [7:0]          cmd_q   [NUM_LEDS];
    logic [5:0]          cnt_q   [NUM_LEDS];
    mode_e               mode_q  [NUM_LEDS];
    // Pin register holds the physical drive level, so the output needs no
    // logic after the flop in either polarity.
    logic [NUM_LEDS-1:0] pins_q;
    logic [NUM_LEDS-1:0] expired_q;

    logic [NUM_LEDS-1:0] load;
    logic [NUM_LEDS-1:0] expire_set;

    // A load is any byte differing from the latched copy; an identical
    // rewrite is ignored. Expiry only fires on a tick that no load overrode.
    always_comb begin
        load       = '0;
        expire_set = '0;
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            load[i]       = (bus.led_commands[8*i +: 8] != cmd_q[i]);
            expire_set[i] = tick_q && !load[i] &&
                            (mode_q[i] == MODE_TIMED) && (cnt_q[i] == 6'd0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pre_cnt   <= '0;
            tick_q    <= 1'b0;
            pins_q    <= {NUM_LEDS{PIN_INV}};
            expired_q <= '0;
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                cmd_q[i]  <= '0;
                cnt_q[i]  <= '0;
                mode_q[i] <= MODE_OFF;
            end
        end else begin
            // Shared prescaler: tick is high for the cycle following the
            // terminal count, so per-LED logic consumes it one edge later.
            if (pre_cnt == PRE_LAST) begin
                pre_cnt <= '0;
                tick_q  <= 1'b1;
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
                tick_q  <= 1'b0;
            end

            // Set wins over a same-cycle clear; loads leave the flag alone.
            expired_q <= expire_set | (expired_q & ~bus.expired_clear);

            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                if (load[i]) begin
                    cmd_q[i]  <= bus.led_commands[8*i +: 8];
                    cnt_q[i]  <= bus.led_commands[8*i +: 6];
                    mode_q[i] <= decode_mode(bus.led_commands[8*i+6 +: 2]);
                    pins_q[i] <= (bus.led_commands[8*i+6 +: 2] != 2'b00) ^ PIN_INV;
                end else if (tick_q) begin
                    case (mode_q[i])
                        MODE_TIMED: begin
                            if (cnt_q[i] == 6'd0) begin
                                pins_q[i] <= PIN_INV;
                                mode_q[i] <= MODE_DONE;
                            end else begin
                                cnt_q[i] <= cnt_q[i] - 6'd1;
                            end
                        end
                        MODE_BLINK: begin
                            if (cnt_q[i] == 6'd0) begin
                                pins_q[i] <= ~pins_q[i];
                                cnt_q[i]  <= cmd_q[i][5:0];
                            end else begin
                                cnt_q[i] <= cnt_q[i] - 6'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.led_pins    = pins_q;
    assign bus.led_expired = expired_q;
    assign bus.tick        = tick_q;

endmodule

// File: tb/tb_led_command_sequencer.sv
// ----------------------------------------------------------------------------
// tb_led_command_sequencer
//   Bench for led_command_sequencer with NUM_LEDS=18, TICK_DIV=4. A reference
//   model tracks, per LED, the latched byte and the number of ticks seen since
//   the last load, and derives pin/expiry from those counts. Every clock is
//   compared against the model; a vector table and hand-written sequences add
//   fixed expectations for reset, prescaler phase, load/tick collision, blink,
//   expiry clear priority and reset abort.
// ----------------------------------------------------------------------------
module tb_led_command_sequencer;

    localparam int unsigned NUM_LEDS = 18;
    localparam int unsigned TICK_DIV = 4;

`ifdef LED_ACTIVE_LOW_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif
    localparam logic [NUM_LEDS-1:0] INV_V = {NUM_LEDS{INV}};

    logic clock = 1'b0;
    logic reset = 1'b1;

    led_command_sequencer_if #(.NUM_LEDS(NUM_LEDS)) bus ();

    led_command_sequencer #(
        .NUM_LEDS (NUM_LEDS),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    int edge_n = 0;

    // ---------------- reference model ----------------
    logic [7:0]          m_cmd   [NUM_LEDS];
    int unsigned         m_ticks [NUM_LEDS];
    logic [NUM_LEDS-1:0] m_exp;
    int unsigned         m_cnt;
    logic                m_tick;

    function automatic logic model_pin(input logic [7:0] c, input int unsigned t);
        int unsigned per;
        per = c[5:0];
        per = per + 1;
        case (c[7:6])
            2'b00:   return 1'b0;
            2'b01:   return 1'b1;
            2'b10:   return (t < per);
            default: return ((t / per) % 2) == 0;
        endcase
    endfunction

    function automatic logic [NUM_LEDS-1:0] model_pins();
        logic [NUM_LEDS-1:0] p;
        for (int i = 0; i < NUM_LEDS; i++) p[i] = model_pin(m_cmd[i], m_ticks[i]);
        return p ^ INV_V;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        logic [7:0]  slice;
        logic        set;
        int unsigned per;
        if (reset) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                m_cmd[i]   = 8'h00;
                m_ticks[i] = 0;
            end
            m_exp  = '0;
            m_cnt  = 0;
            m_tick = 1'b0;
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                slice = bus.led_commands[8*i +: 8];
                set   = 1'b0;
                if (slice != m_cmd[i]) begin
                    m_cmd[i]   = slice;
                    m_ticks[i] = 0;
                end else if (m_tick) begin
                    m_ticks[i] = m_ticks[i] + 1;
                    per = m_cmd[i][5:0];
                    per = per + 1;
                    if (m_cmd[i][7:6] == 2'b10 && m_ticks[i] == per) set = 1'b1;
                end
                m_exp[i] = (m_exp[i] & ~bus.expired_clear[i]) | set;
            end
            m_cnt  = m_cnt + 1;
            m_tick = (m_cnt % TICK_DIV) == 0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %h expected %h", name, edge_n, act, exp);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        if (reset) edge_n = 0;
        else       edge_n++;
        check("model_pins",    32'(bus.led_pins),    32'(model_pins()));
        check("model_expired", 32'(bus.led_expired), 32'(m_exp));
        check("model_tick",    32'(bus.tick),        32'(m_tick));
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) step();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic                  rst;
        logic [NUM_LEDS*8-1:0] cmd;
        logic [NUM_LEDS-1:0]   clr;
        logic [NUM_LEDS-1:0]   pins;
        logic [NUM_LEDS-1:0]   expd;
        logic                  tick;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [7:0] cmd0,
                                input logic pin0, input logic tk);
        vec_t v;
        v.rst  = rst;
        v.cmd  = '0;
        v.cmd[7:0] = cmd0;
        v.clr  = '0;
        v.pins = '0;
        v.pins[0] = pin0;
        v.expd = '0;
        v.tick = tk;
        return v;
    endfunction

    vec_t tbl [14];

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic val;

        bus.led_commands  = '0;
        bus.expired_clear = '0;

        // Reset two cycles, prescaler phase (ticks after edges 4, 8, 12),
        // LED0 ON then OFF with one-cycle load latency.
        tbl[0]  = mk(1'b1, 8'h00, 1'b0, 1'b0);
        tbl[1]  = mk(1'b1, 8'h00, 1'b0, 1'b0);
        tbl[2]  = mk(1'b0, 8'h00, 1'b0, 1'b0);
        tbl[3]  = mk(1'b0, 8'h00, 1'b0, 1'b0);
        tbl[4]  = mk(1'b0, 8'h00, 1'b0, 1'b0);
        tbl[5]  = mk(1'b0, 8'h00, 1'b0, 1'b1);
        tbl[6]  = mk(1'b0, 8'h40, 1'b1, 1'b0);
        tbl[7]  = mk(1'b0, 8'h40, 1'b1, 1'b0);
        tbl[8]  = mk(1'b0, 8'h40, 1'b1, 1'b0);
        tbl[9]  = mk(1'b0, 8'h40, 1'b1, 1'b1);
        tbl[10] = mk(1'b0, 8'h00, 1'b0, 1'b0);
        tbl[11] = mk(1'b0, 8'h00, 1'b0, 1'b0);
        tbl[12] = mk(1'b0, 8'h00, 1'b0, 1'b0);
        tbl[13] = mk(1'b0, 8'h00, 1'b0, 1'b1);

        for (int k = 0; k < 14; k++) begin
            reset             = tbl[k].rst;
            bus.led_commands  = tbl[k].cmd;
            bus.expired_clear = tbl[k].clr;
            step();
            check($sformatf("tbl%0d_pins", k),    32'(bus.led_pins),    32'(tbl[k].pins ^ INV_V));
            check($sformatf("tbl%0d_expired", k), 32'(bus.led_expired), 32'(tbl[k].expd));
            check($sformatf("tbl%0d_tick", k),    32'(bus.tick),        32'(tbl[k].tick));
        end

        // TIMED p=2 on LED5: loaded at edge 14, ticks consumed at 17, 21, 25.
        step();
        bus.led_commands[8*5 +: 8] = 8'h82;
        step();
        check("c3_pin5_on", 32'(bus.led_pins[5]), 32'(1'b1 ^ INV));
        run_to(24);
        check("c3_pin5_before", 32'(bus.led_pins[5]),    32'(1'b1 ^ INV));
        check("c3_exp5_before", 32'(bus.led_expired[5]), 32'(1'b0));
        step();
        check("c3_pin5_off", 32'(bus.led_pins[5]),    32'(1'b0 ^ INV));
        check("c3_exp5_set", 32'(bus.led_expired[5]), 32'(1'b1));
        bus.expired_clear[5] = 1'b1;
        step();
        bus.expired_clear[5] = 1'b0;
        check("c3_exp5_clr", 32'(bus.led_expired[5]), 32'(1'b0));
        check("c3_pin5_held", 32'(bus.led_pins[5]), 32'(1'b0 ^ INV));

        // BLINK p=1 on LED17: loaded at edge 27, toggles at 33, 41, 49, 57.
        bus.led_commands[8*17 +: 8] = 8'hC1;
        step();
        check("c4_pin17_on", 32'(bus.led_pins[17]), 32'(1'b1 ^ INV));
        val = 1'b1;
        for (int t = 0; t < 4; t++) begin
            run_to(32 + 8*t);
            check($sformatf("c4_pre%0d", t), 32'(bus.led_pins[17]), 32'(val ^ INV));
            step();
            val = ~val;
            check($sformatf("c4_post%0d", t), 32'(bus.led_pins[17]), 32'(val ^ INV));
        end

        // TIMED p=0 on LED3 loaded in a tick cycle (edge 61): that tick is
        // ignored, expiry at 65 with a simultaneous clear that must lose.
        run_to(60);
        check("c5_tick_phase", 32'(bus.tick), 32'(1'b1));
        bus.led_commands[8*3 +: 8] = 8'h80;
        step();
        check("c5_pin3_on",  32'(bus.led_pins[3]),    32'(1'b1 ^ INV));
        check("c5_exp3_0",   32'(bus.led_expired[3]), 32'(1'b0));
        run_to(64);
        check("c5_pin3_held", 32'(bus.led_pins[3]), 32'(1'b1 ^ INV));
        bus.expired_clear[3] = 1'b1;
        step();
        bus.expired_clear[3] = 1'b0;
        check("c5_pin3_off",     32'(bus.led_pins[3]),    32'(1'b0 ^ INV));
        check("c5_exp3_setwins", 32'(bus.led_expired[3]), 32'(1'b1));
        check("c5_pin17_tick",   32'(bus.led_pins[17]),   32'(1'b0 ^ INV));

        // Restart LED5 with a different byte, then reset mid-TIMED/mid-BLINK.
        bus.led_commands[8*5 +: 8] = 8'h85;
        step();
        step();
        check("c6_pin5_running", 32'(bus.led_pins[5]), 32'(1'b1 ^ INV));
        reset            = 1'b1;
        bus.led_commands = '0;
        step();
        check("c6_pins_reset", 32'(bus.led_pins),    32'(INV_V));
        check("c6_exp_reset",  32'(bus.led_expired), 32'(0));
        reset = 1'b0;
        run_to(40);
        check("c6_pins_after", 32'(bus.led_pins),    32'(INV_V));
        check("c6_exp_after",  32'(bus.led_expired), 32'(0));

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 5) == 0) begin
                int unsigned led;
                logic [7:0]  b;
                led = $urandom_range(0, NUM_LEDS - 1);
                b[7:6] = 2'($urandom_range(0, 3));
                b[5:0] = 6'($urandom_range(0, 5));
                bus.led_commands[8*led +: 8] = b;
            end
            bus.expired_clear = NUM_LEDS'($urandom & $urandom & $urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
